sc_ifu: RTL and testbench

SC_IFU -- requirements
Module: sc_ifu

---
 rtl/sc_ifu_pkg.sv | 23 ++
 rtl/sc_npc.sv | 38 +++
 rtl/sc_ifu.sv | 120 ++++++++++++
 tb/tb_sc_ifu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM states, pcsource
// encodings and the default reset PC.
package sc_ifu_pkg;

  localparam int unsigned XLEN = 32;

  // Fetch-unit states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Next-PC select codes driven by the control unit
  localparam logic [1:0] PCS_PC4    = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JR     = 2'b10;
  localparam logic [1:0] PCS_JUMP   = 2'b11;

  // PC loaded on reset (must be word-aligned)
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sc_npc.sv
// Combinational next-PC selector.
// Ports:
//   pc4      - address of the current instruction plus 4
//   inst     - current instruction (imm16 / target26 fields)
//   qa       - register rs value, jr target
//   pcsource - 00 pc4, 01 branch, 10 jr, 11 jump
//   next_pc  - selected next PC (may be misaligned for jr)
module sc_npc
  import sc_ifu_pkg::*;
(
  input  logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] qa,
  input  logic [1:0]      pcsource,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] w_br_off;
  logic            w_unused_op;

  // Opcode bits are decoded by the control unit, not here
  assign w_unused_op = ^inst[31:26];

  // Sign-extended word offset of the branch immediate
  assign w_br_off = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    case (pcsource)
      PCS_PC4:    next_pc = pc4;
      PCS_BRANCH: next_pc = pc4 + w_br_off;
      PCS_JR:     next_pc = qa;
      PCS_JUMP:   next_pc = {pc4[31:28], inst[25:0], 2'b00};
      default:    next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/sc_ifu.sv
// Instruction-fetch unit: fetches one word, holds it until the downstream
// commits, then advances the PC according to pcsource.
// Ports:
//   clock, resetn          - clock and async active-low reset
//   pcsource, qa, commit   - next-PC control from the execute side
//   imem_req/addr          - fetch request and address (addr = pc)
//   imem_ready/rdata       - fetch response
//   inst, inst_valid       - latched instruction and hold flag
//   pc, pc4                - current PC and PC+4
//   retired                - committed instruction count
//   err                    - sticky misaligned-target flag
module sc_ifu
  import sc_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] qa,
  input  logic            commit,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] retired,
  output logic            err
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_retired;
  logic            r_err;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_load_inst;
  logic            w_retire;
  logic            w_pc_load;
  logic            w_set_err;

  assign w_pc4 = r_pc + XLEN'(4);

  sc_npc u_npc (
    .pc4      (w_pc4),
    .inst     (r_inst),
    .qa       (qa),
    .pcsource (pcsource),
    .next_pc  (w_next_pc)
  );

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_FETCH;
    else         r_state <= w_state_nxt;
  end

  // Next state and datapath enables
  always_comb begin
    w_state_nxt = r_state;
    w_load_inst = 1'b0;
    w_retire    = 1'b0;
    w_pc_load   = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (imem_ready) begin
          w_load_inst = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (commit) begin
          w_retire = 1'b1;
          // A misaligned target is retired but never fetched
          if (w_next_pc[1:0] != 2'b00) begin
            w_set_err   = 1'b1;
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_load   = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  // PC, instruction latch, retire counter and error flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_retired <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_pc_load)   r_pc      <= w_next_pc;
      if (w_load_inst) r_inst    <= imem_rdata;
      if (w_retire)    r_retired <= r_retired + XLEN'(1);
      if (w_set_err)   r_err     <= 1'b1;
    end
  end

  // Request is gated by reset so it drops the instant reset asserts
  assign imem_req   = resetn & (r_state == ST_FETCH);
  assign imem_addr  = r_pc;
  assign inst       = r_inst;
  assign inst_valid = (r_state == ST_HOLD);
  assign pc         = r_pc;
  assign pc4        = w_pc4;
  assign retired    = r_retired;
  assign err        = r_err;

endmodule

// File: tb/tb_sc_ifu.sv
// Bench for sc_ifu: directed vector table, hand sequences for wait states,
// halt and reset, then randomized traffic against a behavioural model.
module tb_sc_ifu;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] qa = '0;
  logic        commit = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] retired;
  logic        err;

  int checks = 0;
  int failures = 0;

  sc_ifu dut (
    .clock      (clock),
    .resetn     (resetn),
    .pcsource   (pcsource),
    .qa         (qa),
    .commit     (commit),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc4        (pc4),
    .retired    (retired),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rn;
    logic        rdy;
    logic [31:0] rd;
    logic        cm;
    logic [1:0]  ps;
    logic [31:0] q;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_ret;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  logic [31:0] m_pc, m_inst, m_ret;
  logic        m_valid, m_halt, m_err, m_rn;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic e_valid,
                           input logic [31:0] e_pc, input logic [31:0] e_inst,
                           input logic [31:0] e_ret, input logic e_err);
    chk({tag, ".req"},     32'(imem_req),   32'(e_req));
    chk({tag, ".valid"},   32'(inst_valid), 32'(e_valid));
    chk({tag, ".addr"},    imem_addr,       e_pc);
    chk({tag, ".pc"},      pc,              e_pc);
    chk({tag, ".pc4"},     pc4,             e_pc + 32'd4);
    chk({tag, ".inst"},    inst,            e_inst);
    chk({tag, ".retired"}, retired,         e_ret);
    chk({tag, ".err"},     32'(err),        32'(e_err));
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 after the rising edge
  task automatic drive(input logic rn, input logic rdy, input logic [31:0] rd,
                       input logic cm, input logic [1:0] ps, input logic [31:0] q);
    @(negedge clock);
    resetn     = rn;
    imem_ready = rdy;
    imem_rdata = rd;
    commit     = cm;
    pcsource   = ps;
    qa         = q;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_ret = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0; m_err = 1'b0;
  endtask

  // One clock of the fetch unit described by its rules, not its FSM
  task automatic model_step(input logic rn, input logic rdy, input logic [31:0] rd,
                            input logic cm, input logic [1:0] ps, input logic [31:0] q);
    logic [31:0] p4, tgt;
    shortint     s;
    int          imm;
    m_rn = rn;
    if (!rn) begin
      model_reset();
      return;
    end
    if (m_halt) return;
    if (!m_valid) begin
      if (rdy) begin
        m_inst  = rd;
        m_valid = 1'b1;
      end
      return;
    end
    if (!cm) return;
    p4 = m_pc + 32'd4;
    case (ps)
      2'd0: tgt = p4;
      2'd1: begin
        s   = $signed(m_inst[15:0]);
        imm = s;
        tgt = p4 + 32'(imm * 4);
      end
      2'd2: tgt = q;
      default: tgt = (p4 & 32'hF000_0000) | ((m_inst & 32'h03FF_FFFF) * 32'd4);
    endcase
    m_ret   = m_ret + 32'd1;
    m_valid = 1'b0;
    if ((tgt % 32'd4) != 32'd0) begin
      m_err  = 1'b1;
      m_halt = 1'b1;
    end else begin
      m_pc = tgt;
    end
  endtask

  initial begin
    logic        rn, rdy, cm;
    logic [31:0] rd, q;
    logic [1:0]  ps;

    // rn rdy rd cm ps q | req valid pc inst retired err
    tbl.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         32'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h2001_0005, 1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 32'h0,         32'h2001_0005, 32'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 2'b00, 32'h0,         1'b1, 1'b0, 32'h4,         32'h2001_0005, 32'd1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h0800_0040, 1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 32'h4,         32'h0800_0040, 32'd1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 32'h4,         32'h0800_0040, 32'd1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 2'b11, 32'h0,         1'b1, 1'b0, 32'h100,       32'h0800_0040, 32'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h1000_FFFF, 1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 32'h100,       32'h1000_FFFF, 32'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 32'h0,         1'b1, 1'b0, 32'h100,       32'h1000_FFFF, 32'd3, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h0000_0008, 1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 32'h100,       32'h0000_0008, 32'd3, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 2'b10, 32'h0040_0000, 1'b1, 1'b0, 32'h0040_0000, 32'h0000_0008, 32'd4, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h0800_0010, 1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 32'h0040_0000, 32'h0800_0010, 32'd4, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 2'b11, 32'h0,         1'b1, 1'b0, 32'h40,        32'h0800_0010, 32'd5, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h0000_0008, 1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 32'h40,        32'h0000_0008, 32'd5, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 2'b10, 32'h1234,      1'b1, 1'b0, 32'h1234,      32'h0000_0008, 32'd6, 1'b0});

    foreach (tbl[i]) begin
      drive(tbl[i].rn, tbl[i].rdy, tbl[i].rd, tbl[i].cm, tbl[i].ps, tbl[i].q);
      check_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_valid, tbl[i].e_pc,
                tbl[i].e_inst, tbl[i].e_ret, tbl[i].e_err);
    end

    // Slow memory: commit during the wait is ignored, address held
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, (i == 1), 2'b11, 32'h0);
      check_all($sformatf("wait%0d", i), 1'b1, 1'b0, 32'h1234, 32'h0000_0008, 32'd6, 1'b0);
    end
    drive(1'b1, 1'b1, 32'h0080_0008, 1'b0, 2'b00, 32'h0);
    check_all("wait_done", 1'b0, 1'b1, 32'h1234, 32'h0080_0008, 32'd6, 1'b0);

    // Misaligned jr target halts with pc kept and retired bumped
    drive(1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 32'h1002);
    check_all("halt", 1'b0, 1'b0, 32'h1234, 32'h0080_0008, 32'd7, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, $urandom, 1'b1, 2'($urandom), $urandom & 32'hFFFF_FFFC);
      check_all($sformatf("halted%0d", i), 1'b0, 1'b0, 32'h1234, 32'h0080_0008, 32'd7, 1'b1);
    end

    // Reset leaves HALT; first request in the cycle after release
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    check_all("rst1", 1'b0, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    check_all("rel1", 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 32'h0800_0008, 1'b0, 2'b00, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 2'b11, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    check_all("at20", 1'b1, 1'b0, 32'h20, 32'h0800_0008, 32'd1, 1'b0);

    // Reset mid-fetch: request drops at once, pending response discarded
    @(negedge clock);
    resetn     = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    #1;
    chk("midrst.req", 32'(imem_req), 32'h0);
    chk("midrst.pc",  pc,            32'h0);
    @(posedge clock);
    #1;
    check_all("midrst", 1'b0, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    check_all("rel2", 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);

    // PC wrap at the top of the address space
    drive(1'b1, 1'b1, 32'h0, 1'b0, 2'b00, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 32'hFFFF_FFFC);
    chk("top.pc4", pc4, 32'h0);
    drive(1'b1, 1'b1, 32'h0000_1111, 1'b0, 2'b00, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0);
    check_all("wrap", 1'b1, 1'b0, 32'h0, 32'h0000_1111, 32'd2, 1'b0);

    // Randomized traffic against the model
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    model_step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    for (int n = 0; n < 1500; n++) begin
      rn = (($urandom % 64) != 0);
      if (m_halt && (($urandom % 8) == 0)) rn = 1'b0;
      rdy = 1'($urandom % 2);
      rd  = $urandom;
      cm  = 1'($urandom % 2);
      ps  = 2'($urandom % 4);
      q   = (($urandom % 16) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      drive(rn, rdy, rd, cm, ps, q);
      model_step(rn, rdy, rd, cm, ps, q);
      check_all($sformatf("rnd%0d", n), m_rn & ~m_valid & ~m_halt, m_valid, m_pc,
                m_inst, m_ret, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
